// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding and register-address constants.
package hazard_pkg;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } hz_state_t;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

    // Wait counter is wide enough for MEM_TIMEOUT up to 255.
    localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Three free-running event counters for the hazard controller.
// Ports: clk, reset (async, active-high), lu_inc/mw_inc/br_inc strobes,
// perf_lu_stalls/perf_mem_waits/perf_br_flushes WIDTH-bit counts (wrap).
module hazard_perf_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lu_inc,
    input  logic             mw_inc,
    input  logic             br_inc,
    output logic [WIDTH-1:0] perf_lu_stalls,
    output logic [WIDTH-1:0] perf_mem_waits,
    output logic [WIDTH-1:0] perf_br_flushes
);

    logic [WIDTH-1:0] lu_cnt_q, lu_cnt_d;
    logic [WIDTH-1:0] mw_cnt_q, mw_cnt_d;
    logic [WIDTH-1:0] br_cnt_q, br_cnt_d;

    always_comb begin
        lu_cnt_d = lu_cnt_q;
        mw_cnt_d = mw_cnt_q;
        br_cnt_d = br_cnt_q;
        if (lu_inc) lu_cnt_d = lu_cnt_q + 1'b1;
        if (mw_inc) mw_cnt_d = mw_cnt_q + 1'b1;
        if (br_inc) br_cnt_d = br_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lu_cnt_q <= '0;
            mw_cnt_q <= '0;
            br_cnt_q <= '0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
            mw_cnt_q <= mw_cnt_d;
            br_cnt_q <= br_cnt_d;
        end
    end

    assign perf_lu_stalls  = lu_cnt_q;
    assign perf_mem_waits  = mw_cnt_q;
    assign perf_br_flushes = br_cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// branch squash, data-memory wait freeze with a timeout watchdog.
// Inputs: ID source regs/uses, EX rd/load/branch, MEM load/store/ready.
// Outputs: mem_req, pc_en, per-register en/flush, mem_timeout, perf_*.
// Optional: define HAZARD_PERF_EN to build the performance counters;
// otherwise perf_* are tied to zero.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_MemRead,
    input  logic                  ex_branch_taken,
    input  logic                  mem_MemRead,
    input  logic                  mem_MemWrite,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_en,
    output logic                  id_ex_flush,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  mem_wb_flush,
    output logic                  mem_timeout,
    output logic [WIDTH-1:0]      perf_lu_stalls,
    output logic [WIDTH-1:0]      perf_mem_waits,
    output logic [WIDTH-1:0]      perf_br_flushes
);

    localparam logic [WAIT_CNT_W-1:0] LAST_CNT =
        WAIT_CNT_W'(MEM_TIMEOUT - 1);

    hz_state_t state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic memop;
    logic expire;
    logic hold;
    logic branch;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;

    assign memop  = mem_MemRead | mem_MemWrite;
    assign expire = (state_q == MEM_WAIT) && (wait_cnt_q == LAST_CNT);
    assign hold   = memop & ~mem_ready & ~expire;
    assign branch = ex_branch_taken;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_MemRead && (ex_rd != X0) && (rs1_hit || rs2_hit);

    // Next state. A memop that vanishes mid-wait is illegal, so only
    // mem_ready or the watchdog can leave MEM_WAIT.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                if (hold) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready || expire) begin
                    state_d = RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Output decode. Reset overrides everything so that mem_req drops
    // and all pipeline registers flush without waiting for a clock.
    always_comb begin
        mem_req      = memop;
        mem_timeout  = expire;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        mem_wb_flush = 1'b0;
        if (reset) begin
            mem_req      = 1'b0;
            mem_timeout  = 1'b0;
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_en     = 1'b0;
            id_ex_flush  = 1'b1;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (hold) begin
            // Freeze everything; a bubble drains into WB.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (branch) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID one cycle, bubble into EX.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic lu_inc;
    logic br_inc;

    assign br_inc = ~hold & branch;
    assign lu_inc = ~hold & ~branch & load_use;

    hazard_perf_cnt #(
        .WIDTH(WIDTH)
    ) u_perf (
        .clk            (clk),
        .reset          (reset),
        .lu_inc         (lu_inc),
        .mw_inc         (hold),
        .br_inc         (br_inc),
        .perf_lu_stalls (perf_lu_stalls),
        .perf_mem_waits (perf_mem_waits),
        .perf_br_flushes(perf_br_flushes)
    );
`else
    assign perf_lu_stalls  = '0;
    assign perf_mem_waits  = '0;
    assign perf_br_flushes = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable.
- Resolves three event types: load-use data hazards, branch-taken redirects and multi-cycle data-memory accesses.
- Owns the data-memory request/ready handshake, including a timeout watchdog.

Parameters:
- WIDTH, 32, width of the performance counters.
- MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before a forced release; range 1..255.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- id_rs1  input  5  rs1 of the instruction in ID.
- id_rs2  input  5  rs2 of the instruction in ID.
- id_uses_rs1  input  1  the ID instruction reads rs1.
- id_uses_rs2  input  1  the ID instruction reads rs2.
- ex_rd  input  5  rd of the instruction in EX.
- ex_MemRead  input  1  the EX instruction is a load.
- ex_branch_taken  input  1  branch/jump resolved taken in EX.
- mem_MemRead  input  1  the MEM-stage instruction is a load.
- mem_MemWrite  input  1  the MEM-stage instruction is a store.
- mem_ready  input  1  data memory completes the access this cycle.
- mem_req  output  1  data-memory access request.
- pc_en  output  1  PC update enable.
- if_id_en  output  1  IF/ID register enable.
- if_id_flush  output  1  IF/ID register flush.
- id_ex_en  output  1  ID/EX register enable.
- id_ex_flush  output  1  ID/EX register flush.
- ex_mem_en  output  1  EX/MEM register enable.
- mem_wb_en  output  1  MEM/WB register enable.
- mem_wb_flush  output  1  MEM/WB register flush.
- mem_timeout  output  1  one-cycle pulse on watchdog expiry.
- perf_lu_stalls  output  WIDTH  load-use stall count.
- perf_mem_waits  output  WIDTH  memory wait-cycle count.
- perf_br_flushes  output  WIDTH  branch flush count.

Behaviour:
- Reset is asynchronous and active-high. While reset=1:
  - state=RUN, wait_cnt=0, counters=0.
  - All *_en=0, all *_flush=1, mem_req=0, mem_timeout=0.
- States are RUN and MEM_WAIT. Outputs are combinational from state and inputs; state and wait_cnt are registered.
- Derived signals:
  - memop = mem_MemRead|mem_MemWrite.
  - mem_req = memop in both states.
  - hold = memop & !mem_ready & !expire.
  - expire = (state==MEM_WAIT) & (wait_cnt==MEM_TIMEOUT-1).
- Priority, highest first:
  - 1. hold: all *_en=0, mem_wb_flush=1, other flushes 0. The pipeline is frozen and a bubble enters WB.
  - 2. branch (ex_branch_taken): all *_en=1, if_id_flush=1, id_ex_flush=1. The two younger instructions are squashed. Load-use is ignored this cycle.
  - 3. load-use (ex_MemRead & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))): pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. Exactly one bubble is inserted per hazard.
  - 4. otherwise: all *_en=1, all flushes 0.
- Transitions:
  - RUN->MEM_WAIT when hold. wait_cnt is cleared.
  - MEM_WAIT->RUN when mem_ready=1 or expire. In that cycle priorities 2-4 apply, so a branch held during the freeze is honoured on release.
  - MEM_WAIT stays when hold. wait_cnt increments.
- Zero-wait access: memop & mem_ready in RUN never leaves RUN and does not stall.
- Watchdog:
  - On expire, mem_timeout pulses for 1 cycle and the pipeline advances as if mem_ready=1.
  - The MEM/WB capture on the expire cycle is not flushed; the datapath owns the bad-data policy.
- A memop that drops during MEM_WAIT is not a legal stimulus; the controller stays in MEM_WAIT until mem_ready or expire.
- Reset asserted mid-MEM_WAIT returns to RUN immediately. mem_req deasserts asynchronously.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - perf_lu_stalls increments on each load-use cycle (priority 3 taken).
  - perf_mem_waits increments on each hold cycle.
  - perf_br_flushes increments on each branch cycle (priority 2 taken).
  - Counters wrap at 2^WIDTH and are cleared only by reset.
- Undefined: all perf_* outputs are constant 0 and no counter flops are built.

Decomposition:
- hazard_pkg holds:
  - typedef enum logic {RUN, MEM_WAIT} hz_state_t.
  - localparam REG_ADDR_W=5.
  - localparam X0=5'd0.
- Sub-module hazard_perf_cnt: three WIDTH-bit counters with increment strobes, instantiated only under HAZARD_PERF_EN.

Test Plan:
- Load-use: ex_MemRead=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; then all en=1. With ex_rd=0 -> no stall.
- Branch: ex_branch_taken=1 together with a load-use match -> if_id_flush=1, id_ex_flush=1, pc_en=1; load-use ignored; perf_br_flushes=1, perf_lu_stalls=0.
- Memory wait: mem_MemRead=1, mem_ready low for 3 cycles then high -> 3 cycles of all en=0 with mem_wb_flush=1; release cycle en=1; perf_mem_waits=3; state back to RUN.
- Timeout: MEM_TIMEOUT=4, mem_MemWrite=1, mem_ready held 0 -> mem_timeout pulses on the 5th cycle of the access (first freeze cycle plus 4 MEM_WAIT cycles); pipeline advances; mem_req follows memop.
- Freeze with branch pending: ex_branch_taken=1 during a 2-cycle wait -> no flush while frozen; flushes asserted on the release cycle.
- Async reset asserted mid-MEM_WAIT (no clock edge) -> mem_req=0, all flushes=1 immediately; after release, state RUN and counters 0.
